// File: rtl/spike_collector_if.sv
// Bus bundle between the neuron array, the spike collector and the downstream stream consumer.
// The collector uses the slave view; the environment driving lanes and ready uses the master view.
interface spike_collector_if #(
  parameter int N  = 8,
  parameter int S  = 16,
  parameter int UW = 8
);
  localparam int TW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_tvalid;
  logic [N*S-1:0]  in_tdata;
  logic [N*UW-1:0] in_tuser;
  logic            out_tvalid;
  logic            out_tready;
  logic [S-1:0]    out_tdata;
  logic [UW-1:0]   out_tuser;
  logic [TW-1:0]   out_tid;
  logic            out_tlast;
  logic [N-1:0]    captured;
  logic            all_done;

  modport slave (
    input  in_tvalid, in_tdata, in_tuser, out_tready,
    output out_tvalid, out_tdata, out_tuser, out_tid, out_tlast, captured, all_done
  );

  modport master (
    output in_tvalid, in_tdata, in_tuser, out_tready,
    input  out_tvalid, out_tdata, out_tuser, out_tid, out_tlast, captured, all_done
  );
endinterface

// File: rtl/spike_collector.sv
// Collects one result beat per neuron per inference through a round-robin arbiter and
// serialises them via a small FIFO onto a single AXI-stream tagged with the neuron index.
module spike_collector #(
  parameter int N  = 8,
  parameter int S  = 16,
  parameter int UW = 8,
  parameter int FD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  spike_collector_if.slave  bus
);
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FD);

  typedef struct packed {
    logic [TW-1:0] tid;
    logic [S-1:0]  tdata;
    logic [UW-1:0] tuser;
    logic          last;
  } entry_t;

  logic [N-1:0]  captured_q, captured_d;
  logic [TW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          all_done_q, all_done_d;
  entry_t        mem_q [FD];

  logic [S-1:0]  lane_data [N];
  logic [UW-1:0] lane_user [N];
  logic [N-1:0]  pending;
  logic [N-1:0]  grant_oh;
  logic [TW-1:0] grant_idx;
  logic          grant_found;
  logic          push, pop, full, empty;
  entry_t        push_entry, head;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_data[i] = bus.in_tdata[i*S +: S];
    assign lane_user[i] = bus.in_tuser[i*UW +: UW];
  end

  assign pending = bus.in_tvalid & ~captured_q;
  assign full    = (count_q == (AW+1)'(FD));
  assign empty   = (count_q == '0);

  // Scan from rr_ptr upward with explicit modulo-N wrap so non-power-of-2 N works.
  always_comb begin
    logic [TW:0] idx_ext;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_ext     = '0;
    for (int k = 0; k < N; k++) begin
      idx_ext = {1'b0, rr_ptr_q} + (TW+1)'(k);
      if (idx_ext >= (TW+1)'(N)) idx_ext = idx_ext - (TW+1)'(N);
      if (!grant_found && pending[idx_ext[TW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_ext[TW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
    // clear wins over both the grant and the pop of the same cycle
    push = grant_found & ~full & ~clear;
    pop  = ~empty & bus.out_tready & ~clear;

    push_entry.tid   = grant_idx;
    push_entry.tdata = lane_data[grant_idx];
    push_entry.tuser = lane_user[grant_idx];
    push_entry.last  = &(captured_q | grant_oh);

    captured_d = captured_q;
    rr_ptr_d   = rr_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    all_done_d = all_done_q;

    if (clear) begin
      captured_d = '0;
      rr_ptr_d   = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      all_done_d = 1'b0;
    end else begin
      if (push) begin
        captured_d = captured_q | grant_oh;
        rr_ptr_d   = (grant_idx == TW'(N-1)) ? '0 : grant_idx + 1'b1;
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (&captured_d && (count_d == '0)) all_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      captured_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      all_done_q <= 1'b0;
    end else begin
      captured_q <= captured_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      all_done_q <= all_done_d;
    end
  end

  // Payload storage carries no reset; outputs are masked by empty instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.out_tvalid = ~empty;
  assign bus.out_tdata  = empty ? '0 : head.tdata;
  assign bus.out_tuser  = empty ? '0 : head.tuser;
  assign bus.out_tid    = empty ? '0 : head.tid;
  assign bus.out_tlast  = empty ? 1'b0 : head.last;
  assign bus.captured   = captured_q;
  assign bus.all_done   = all_done_q;
endmodule

// File: tb/tb_spike_collector.sv
// Directed and randomized bench for spike_collector, checked against a queue-based reference model.
module tb_spike_collector;
  localparam int N  = 8;
  localparam int S  = 16;
  localparam int UW = 8;
  localparam int FD = 4;

  typedef struct {
    int            tid;
    logic [S-1:0]  d;
    logic [UW-1:0] u;
    bit            last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;

  bit   [N-1:0]  lane_v;
  logic [S-1:0]  lane_d [N];
  logic [UW-1:0] lane_u [N];
  bit            rdy;

  beat_t  mq[$];
  bit [N-1:0] mcap;
  int     mrr;
  bit     mdone;
  int     obs_tid[$];

  int checks = 0;
  int failures = 0;

  spike_collector_if #(.N(N), .S(S), .UW(UW)) bus ();

  spike_collector #(.N(N), .S(S), .UW(UW), .FD(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.in_tvalid  = lane_v;
    bus.out_tready = rdy;
    for (int i = 0; i < N; i++) begin
      bus.in_tdata[i*S +: S]   = lane_d[i];
      bus.in_tuser[i*UW +: UW] = lane_u[i];
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mcap  = '0;
    mrr   = 0;
    mdone = 1'b0;
  endtask

  task automatic compare();
    check("out_tvalid", bus.out_tvalid, mq.size() > 0);
    if (mq.size() > 0) begin
      check("out_tid",   bus.out_tid,   mq[0].tid);
      check("out_tdata", bus.out_tdata, mq[0].d);
      check("out_tuser", bus.out_tuser, mq[0].u);
      check("out_tlast", bus.out_tlast, mq[0].last);
    end
    check("captured", bus.captured, mcap);
    check("all_done", bus.all_done, mdone);
  endtask

  // One clock: advance the reference model by the rules, then compare after the edge.
  task automatic step();
    beat_t b;
    int g;
    bit [N-1:0] pend;
    bit [N-1:0] tmp;
    drive();
    if (bus.out_tvalid && rdy) obs_tid.push_back(int'(bus.out_tid));
    g = -1;
    pend = lane_v & ~mcap;
    if (mq.size() < FD)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(mrr + k) % N]) g = (mrr + k) % N;
    if (clear) begin
      model_reset();
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (g >= 0) begin
        tmp    = mcap;
        tmp[g] = 1'b1;
        b.tid  = g;
        b.d    = lane_d[g];
        b.u    = lane_u[g];
        b.last = &tmp;
        mq.push_back(b);
        mcap = tmp;
        mrr  = (g + 1) % N;
      end
      if (&mcap && mq.size() == 0) mdone = 1'b1;
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    clear  = 1'b1;
    lane_v = '0;
    step();
    clear = 1'b0;
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < N; i++) begin
      lane_d[i] = S'($urandom);
      lane_u[i] = UW'($urandom);
    end
  endtask

  task automatic check_order(input string tag, input int n);
    check({tag, "_count"}, obs_tid.size(), n);
    for (int i = 0; i < n; i++)
      check({tag, "_tid"}, (i < obs_tid.size()) ? obs_tid[i] : -1, i);
  endtask

  initial begin
    logic [S-1:0] frozen_d;
    lane_v = '0;
    rdy    = 1'b0;
    for (int i = 0; i < N; i++) begin
      lane_d[i] = '0;
      lane_u[i] = '0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid",   bus.out_tvalid, 0);
    check("rst_tdata",    bus.out_tdata, 0);
    check("rst_tuser",    bus.out_tuser, 0);
    check("rst_tid",      bus.out_tid, 0);
    check("rst_tlast",    bus.out_tlast, 0);
    check("rst_captured", bus.captured, 0);
    check("rst_all_done", bus.all_done, 0);
    model_reset();
    reset = 1'b1;

    // Single lane, one-cycle latency, no repeat while lane stays valid
    lane_d[3] = 16'hA5A5;
    lane_u[3] = 8'd7;
    lane_v[3] = 1'b1;
    rdy = 1'b1;
    step();
    check("t1_tvalid", bus.out_tvalid, 1);
    check("t1_tid",    bus.out_tid, 3);
    check("t1_tdata",  bus.out_tdata, 16'hA5A5);
    check("t1_tuser",  bus.out_tuser, 7);
    check("t1_tlast",  bus.out_tlast, 0);
    run(4);
    check("t1_norepeat", bus.out_tvalid, 0);
    check("t1_captured", bus.captured, 8'h08);
    do_clear();

    // All lanes at once
    randomize_lanes();
    lane_v = '1;
    obs_tid.delete();
    run(10);
    check_order("t2_order", N);
    check("t2_all_done", bus.all_done, 1);
    do_clear();
    check("t2_done_cleared", bus.all_done, 0);

    // Round-robin wrap: after lane 4, lanes 1 and 6 -> 6 then 1
    lane_v[4] = 1'b1;
    run(3);
    obs_tid.delete();
    lane_v[1] = 1'b1;
    lane_v[6] = 1'b1;
    run(4);
    check("t3_count", obs_tid.size(), 2);
    check("t3_first",  (obs_tid.size() > 0) ? obs_tid[0] : -1, 6);
    check("t3_second", (obs_tid.size() > 1) ? obs_tid[1] : -1, 1);
    do_clear();

    // Backpressure with a full FIFO
    rdy = 1'b0;
    randomize_lanes();
    lane_v = '1;
    obs_tid.delete();
    step();
    frozen_d = lane_d[0];
    run(5);
    check("t4_captured", bus.captured, 8'h0F);
    check("t4_frozen_tid", bus.out_tid, 0);
    check("t4_frozen_tdata", bus.out_tdata, frozen_d);
    check("t4_no_pops", obs_tid.size(), 0);
    rdy = 1'b1;
    run(12);
    check_order("t4_order", N);
    do_clear();

    // clear with two queued entries and a grant pending
    rdy = 1'b0;
    lane_v[0] = 1'b1;
    lane_v[1] = 1'b1;
    run(2);
    lane_v[5] = 1'b1;
    clear = 1'b1;
    step();
    clear  = 1'b0;
    lane_v = '0;
    check("t5_tvalid",   bus.out_tvalid, 0);
    check("t5_captured", bus.captured, 0);
    check("t5_all_done", bus.all_done, 0);
    step();
    check("t5_nopush", bus.out_tvalid, 0);

    // Async reset mid-burst
    randomize_lanes();
    lane_v = '1;
    for (int i = 0; i < 3; i++) begin
      rdy = 1'($urandom_range(0, 1));
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    check("t6_tvalid",   bus.out_tvalid, 0);
    check("t6_tid",      bus.out_tid, 0);
    check("t6_tdata",    bus.out_tdata, 0);
    check("t6_tuser",    bus.out_tuser, 0);
    check("t6_tlast",    bus.out_tlast, 0);
    check("t6_captured", bus.captured, 0);
    check("t6_all_done", bus.all_done, 0);
    model_reset();
    #2;
    reset = 1'b1;
    rdy = 1'b1;
    obs_tid.delete();
    run(10);
    check_order("t6_restart", N);

    // Randomized arrival and backpressure
    for (int r = 0; r < 4; r++) begin
      do_clear();
      randomize_lanes();
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 2) == 0) lane_v[$urandom_range(0, N-1)] = 1'b1;
        rdy = ($urandom_range(0, 3) != 0);
        step();
      end
      lane_v = '1;
      rdy = 1'b1;
      run(12);
      check("rand_all_done", bus.all_done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
